// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register carrying a multi-lane bundle through a 2-entry skid buffer.
// in_ready is registered; flush drops all held and incoming bundles; bp_cycles counts stalled cycles.
module pipe_skid_stage #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       LANES     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        bp_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam logic [LANES*DATA_W-1:0] NOP_BUNDLE = {LANES{NOP_VALUE}};

    state_e                  state_q;
    logic [LANES-1:0]        m_valid_q, s_valid_q;
    logic [LANES*DATA_W-1:0] m_data_q, s_data_q;
    logic                    in_ready_q;
    logic [CNT_W-1:0]        bp_q, bp_d;
    logic [LANES*DATA_W-1:0] in_masked;
    logic                    accept;
    logic                    stalled;

    // Invalid lanes are stored as NOP so out_data never leaks stale payload.
    always_comb begin
        in_masked = NOP_BUNDLE;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (in_valid[l]) begin
                in_masked[l*DATA_W +: DATA_W] = in_data[l*DATA_W +: DATA_W];
            end
        end
    end

    assign accept  = in_ready_q & (|in_valid);
    assign stalled = (|m_valid_q) & ~out_ready;

    always_comb begin
        bp_d = bp_q;
        if (stalled && (bp_q != '1)) begin
            bp_d = bp_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            m_valid_q  <= '0;
            m_data_q   <= NOP_BUNDLE;
            s_valid_q  <= '0;
            s_data_q   <= NOP_BUNDLE;
            in_ready_q <= 1'b1;
            bp_q       <= '0;
        end else begin
            bp_q <= bp_d;
            if (flush) begin
                state_q    <= EMPTY;
                m_valid_q  <= '0;
                m_data_q   <= NOP_BUNDLE;
                s_valid_q  <= '0;
                s_data_q   <= NOP_BUNDLE;
                in_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            m_valid_q <= in_valid;
                            m_data_q  <= in_masked;
                            state_q   <= FULL;
                        end
                    end
                    FULL: begin
                        if (out_ready) begin
                            if (accept) begin
                                m_valid_q <= in_valid;
                                m_data_q  <= in_masked;
                            end else begin
                                m_valid_q <= '0;
                                m_data_q  <= NOP_BUNDLE;
                                state_q   <= EMPTY;
                            end
                        end else if (accept) begin
                            s_valid_q  <= in_valid;
                            s_data_q   <= in_masked;
                            in_ready_q <= 1'b0;
                            state_q    <= SKID;
                        end
                    end
                    SKID: begin
                        if (out_ready) begin
                            m_valid_q  <= s_valid_q;
                            m_data_q   <= s_data_q;
                            s_valid_q  <= '0;
                            s_data_q   <= NOP_BUNDLE;
                            in_ready_q <= 1'b1;
                            state_q    <= FULL;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign occupancy = state_q;
    assign bp_cycles = bp_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage with a bundle scoreboard; a 4-bit-counter instance checks saturation.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 64;
    localparam int unsigned NL = 2;

    typedef struct {
        logic [NL-1:0]    v;
        logic [NL*DW-1:0] d;
    } bundle_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [NL-1:0]     in_valid;
    logic [NL*DW-1:0]  in_data;
    logic              in_ready, in_ready4;
    logic [NL-1:0]     out_valid, out_valid4;
    logic [NL*DW-1:0]  out_data, out_data4;
    logic              out_ready;
    logic [1:0]        occupancy, occupancy4;
    logic [31:0]       bp_cycles;
    logic [3:0]        bp_cycles4;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bundle_t     sb[$];
    logic [31:0] exp_bp;
    logic [3:0]  exp_bp4;

    pipe_skid_stage #(.DATA_W(DW), .LANES(NL), .NOP_VALUE('0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy), .bp_cycles(bp_cycles)
    );

    pipe_skid_stage #(.DATA_W(DW), .LANES(NL), .NOP_VALUE('0), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready), .occupancy(occupancy4), .bp_cycles(bp_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NL*DW-1:0] obs, input logic [NL*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [NL-1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = {d1, d0};
        out_ready = ordy;
        flush     = fl;
    endtask

    // Settle scoreboard for the coming edge, advance one clock, then check counters.
    task automatic cycle();
        bundle_t b;
        if (rst) begin
            sb.delete();
            exp_bp  = '0;
            exp_bp4 = '0;
        end else begin
            if ((|out_valid) && !out_ready) begin
                if (exp_bp != '1) exp_bp++;
                if (exp_bp4 != '1) exp_bp4++;
            end
            if ((|out_valid) && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {{(NL*DW-NL){1'b0}}, out_valid}, '0);
                end else begin
                    b = sb.pop_front();
                    check("sb_valid", {{(NL*DW-NL){1'b0}}, out_valid}, {{(NL*DW-NL){1'b0}}, b.v});
                    check("sb_data", out_data, b.d);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_ready && (|in_valid)) begin
                b.v = in_valid;
                for (int l = 0; l < NL; l++)
                    b.d[l*DW +: DW] = in_valid[l] ? in_data[l*DW +: DW] : '0;
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        check("bp32", {96'd0, bp_cycles}, {96'd0, exp_bp});
        check("bp4", {124'd0, bp_cycles4}, {124'd0, exp_bp4});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_occ"}, {126'd0, occupancy}, '0);
        check({tag, "_in_ready"}, {127'd0, in_ready}, {127'd0, 1'b1});
        check({tag, "_out_valid"}, {126'd0, out_valid}, '0);
        check({tag, "_out_data"}, out_data, '0);
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        check_idle("reset0");

        // Saturation: hold bundle A under back-pressure for 20 cycles
        drive(2'b11, 64'hA1, 64'hA2, 1'b0, 1'b0);
        cycle();
        drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle();
        check("sat_bp4", {124'd0, bp_cycles4}, {124'd0, 4'd15});
        check("sat_bp32", {96'd0, bp_cycles}, 128'd20);
        drive(2'b11, 64'hB1, 64'hB2, 1'b0, 1'b0);
        cycle();
        check("sat_bp4_hold", {124'd0, bp_cycles4}, {124'd0, 4'd15});
        check("skid_occ", {126'd0, occupancy}, 128'd2);
        check("skid_in_ready", {127'd0, in_ready}, '0);

        // Reset while two bundles are held
        rst = 1'b1;
        drive(2'b11, 64'hC1, 64'hC2, 1'b1, 1'b0);
        cycle();
        rst = 1'b0;
        check_idle("reset_skid");
        check("reset_bp", {96'd0, bp_cycles}, '0);

        // Streaming: one bundle per cycle, no gaps
        for (int i = 1; i <= 8; i++) begin
            drive(2'b11, 64'(i), 64'(i + 100), 1'b1, 1'b0);
            cycle();
            check("stream_occ", {126'd0, occupancy}, 128'd1);
            check("stream_valid", {126'd0, out_valid}, 128'd3);
            check("stream_data", out_data, {64'(i + 100), 64'(i)});
        end
        drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
        cycle();
        check("stream_end_occ", {126'd0, occupancy}, '0);

        // Back-pressure: A then B, hold 3, then drain in order
        drive(2'b11, 64'hAAA1, 64'hAAA2, 1'b0, 1'b0);
        cycle();
        drive(2'b11, 64'hBBB1, 64'hBBB2, 1'b0, 1'b0);
        cycle();
        check("bp_occ2", {126'd0, occupancy}, 128'd2);
        check("bp_in_ready0", {127'd0, in_ready}, '0);
        drive(2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_stable", out_data, {64'hAAA2, 64'hAAA1});
        end
        check("bp_count", {96'd0, bp_cycles}, 128'd4);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
        cycle();
        check("drainA_occ", {126'd0, occupancy}, 128'd1);
        check("drainA_in_ready", {127'd0, in_ready}, {127'd0, 1'b1});
        cycle();
        check("drainB_occ", {126'd0, occupancy}, '0);
        check("drain_bp", {96'd0, bp_cycles}, 128'd4);

        // Partial bundle and bubbles
        drive(2'b01, 64'h1234, 64'hDEAD, 1'b1, 1'b0);
        cycle();
        check("partial_valid", {126'd0, out_valid}, 128'd1);
        check("partial_lane1", {64'd0, out_data[127:64]}, '0);
        drive(2'b00, 64'h55, 64'h66, 1'b1, 1'b0);
        cycle();
        check("bubble_occ0", {126'd0, occupancy}, '0);
        drive(2'b10, 64'hC0, 64'hC1, 1'b0, 1'b0);
        cycle();
        drive(2'b00, 64'h77, 64'h88, 1'b0, 1'b0);
        cycle();
        check("bubble_occ1", {126'd0, occupancy}, 128'd1);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
        cycle();

        // Flush in SKID with a new bundle presented
        drive(2'b11, 64'hD1, 64'hD2, 1'b0, 1'b0);
        cycle();
        drive(2'b11, 64'hE1, 64'hE2, 1'b0, 1'b0);
        cycle();
        check("pre_flush_occ", {126'd0, occupancy}, 128'd2);
        drive(2'b11, 64'hF1, 64'hF2, 1'b0, 1'b1);
        cycle();
        check_idle("flush");
        check("flush_bp_kept", {96'd0, bp_cycles}, 128'd7);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
        cycle();
        check_idle("post_flush");

        check("sb_empty", 128'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
